// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame length and parity helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int MAX_DATA_WIDTH = 32;

    function automatic int number_of_bits(input int data_width, input int parity_enabled);
        return data_width + parity_enabled + 2;
    endfunction

    // Zero-extension leaves the XOR unchanged, so any width up to MAX_DATA_WIDTH fits.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and received-word signals between the pad, the receiver and the UART top.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] received_data;
    logic                  data_is_valid;
    logic                  rx_error;
    logic                  rx_busy;

    modport master (
        input  serial_in,
        output received_data,
        output data_is_valid,
        output rx_error,
        output rx_busy
    );

    modport slave (
        output serial_in,
        input  received_data,
        input  data_is_valid,
        input  rx_error,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_synchronizer.sv
// Multi-stage flip-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line never looks like a start bit.
module uart_rx_synchronizer #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sync_chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_chain <= '1;
        end else begin
            sync_chain[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    assign q = sync_chain[DEPTH-1];
endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes serial_in, samples each bit at mid-bit, checks parity
// and stop bit, and reports the byte with a one-cycle valid or error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH           = 8,
    parameter int PARITY_ENABLED             = 1,
    parameter int PARITY_TYPE                = 0,
    parameter int CLOCKS_PER_BIT             = 8,
    parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
    input logic       clk,
    input logic       reset,
    uart_rx_if.master rx_if
);
    localparam int TICK_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W  = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

    rx_state_t                   state;
    logic                        rx_s;
    logic [TICK_W-1:0]           tick_cnt;
    logic [IDX_W-1:0]            bit_idx;
    logic [INPUT_DATA_WIDTH-1:0] shift_data;
    logic [INPUT_DATA_WIDTH-1:0] received_data;
    logic                        parity_err;
    logic                        armed;
    logic                        data_is_valid;
    logic                        rx_error;
    logic                        rx_busy;

    uart_rx_synchronizer #(
        .DEPTH(NUMBER_OF_RX_SYNCHRONIZERS)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx_if.serial_in),
        .q    (rx_s)
    );

    // armed blocks a new start until the line has been seen high again after a break.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= RX_IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shift_data    <= '0;
            parity_err    <= 1'b0;
            armed         <= 1'b1;
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state      <= RX_START;
                        rx_busy    <= 1'b1;
                        parity_err <= 1'b0;
                        tick_cnt   <= TICK_W'(CLOCKS_PER_BIT/2 - 1);
                    end
                end
                RX_START: begin
                    if (tick_cnt == '0) begin
                        tick_cnt <= TICK_W'(CLOCKS_PER_BIT - 1);
                        if (rx_s) begin
                            state   <= RX_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt == '0) begin
                        tick_cnt            <= TICK_W'(CLOCKS_PER_BIT - 1);
                        shift_data[bit_idx] <= rx_s;
                        if (bit_idx == IDX_W'(INPUT_DATA_WIDTH - 1)) begin
                            state <= (PARITY_ENABLED != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (tick_cnt == '0) begin
                        tick_cnt   <= TICK_W'(CLOCKS_PER_BIT - 1);
                        parity_err <= (rx_s != calc_parity(MAX_DATA_WIDTH'(shift_data),
                                                           (PARITY_TYPE != 0)));
                        state      <= RX_STOP;
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_cnt == '0) begin
                        state   <= RX_IDLE;
                        rx_busy <= 1'b0;
                        armed   <= rx_s;
                        if (rx_s && !parity_err) begin
                            data_is_valid <= 1'b1;
                            received_data <= shift_data;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.received_data = received_data;
    assign rx_if.data_is_valid = data_is_valid;
    assign rx_if.rx_error      = rx_error;
    assign rx_if.rx_busy       = rx_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, expected pulses queued,
// and a negedge monitor compares kind, data and arrival cycle of every pulse.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB     = 8;
    localparam int LATENCY = 88;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [7:0] model_data;

    uart_rx_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx #(
        .INPUT_DATA_WIDTH          (8),
        .PARITY_ENABLED            (1),
        .PARITY_TYPE               (0),
        .CLOCKS_PER_BIT            (CPB),
        .NUMBER_OF_RX_SYNCHRONIZERS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx_if(rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveBit(input logic b);
        rx_if.serial_in = b;
        waitCycles(CPB);
    endtask

    // Queues the expected pulse, then drives start, data LSB first, parity and stop.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                                 input logic expect_err);
        exp_t e;
        e.is_err = expect_err;
        e.cycle  = cycle + LATENCY;
        if (!expect_err) model_data = data;
        e.data = model_data;
        exp_q.push_back(e);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(par);
        driveBit(stop);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && (rx_if.data_is_valid || rx_if.rx_error)) begin
            checkOutput("pulse_exclusive", 32'(rx_if.data_is_valid & rx_if.rx_error), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0b error=%0b expected none (cycle %0d)",
                         rx_if.data_is_valid, rx_if.rx_error, cycle);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_kind", 32'(rx_if.rx_error), 32'(e.is_err));
                checkOutput("pulse_data", 32'(rx_if.received_data), 32'(e.data));
                checkOutput("pulse_cycle", cycle, e.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish before 200000 ns");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int busy_count;
        rx_if.serial_in = 1'b1;
        reset           = 1'b0;
        model_data      = 8'h00;
        waitCycles(5);
        checkOutput("reset_data", 32'(rx_if.received_data), 32'h00);
        checkOutput("reset_valid", 32'(rx_if.data_is_valid), 32'd0);
        checkOutput("reset_error", 32'(rx_if.rx_error), 32'd0);
        checkOutput("reset_busy", 32'(rx_if.rx_busy), 32'd0);
        reset = 1'b1;
        waitCycles(10);

        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0);
        waitCycles(16);

        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
        waitCycles(16);

        applyStimulus(8'h01, 1'b0, 1'b1, 1'b1);
        waitCycles(16);

        // Stop bit 0 and the line left low: a break must not start another frame.
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
        waitCycles(24);
        checkOutput("break_busy", 32'(rx_if.rx_busy), 32'd0);
        driveBit(1'b1);
        driveBit(1'b1);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0);
        waitCycles(16);

        rx_if.serial_in = 1'b0;
        waitCycles(2);
        rx_if.serial_in = 1'b1;
        busy_count = 0;
        for (int i = 0; i < 24; i++) begin
            if (rx_if.rx_busy) busy_count++;
            waitCycles(1);
        end
        checkOutput("glitch_busy_cycles", busy_count, 32'd4);
        waitCycles(8);

        // Abandon a frame of 0x77 in the middle of data bit 5.
        driveBit(1'b0);
        for (int i = 0; i < 5; i++) driveBit(1'b1 & (8'h77 >> i));
        rx_if.serial_in = 1'b1;
        waitCycles(3);
        checkOutput("midframe_busy", 32'(rx_if.rx_busy), 32'd1);
        reset = 1'b0;
        waitCycles(1);
        model_data = 8'h00;
        checkOutput("midreset_data", 32'(rx_if.received_data), 32'h00);
        checkOutput("midreset_valid", 32'(rx_if.data_is_valid), 32'd0);
        checkOutput("midreset_error", 32'(rx_if.rx_error), 32'd0);
        checkOutput("midreset_busy", 32'(rx_if.rx_busy), 32'd0);
        reset = 1'b1;
        waitCycles(16);
        applyStimulus(8'h96, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) waitCycles(1);
        checkOutput("pending_pulses", exp_q.size(), 32'd0);
        waitCycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Stand-alone UART receiver. It is the receive end of the team's UART link, frame-compatible with the existing transmitter.
- Takes the asynchronous serial_in line and synchronizes it.
- Oversamples at CLOCKS_PER_BIT clocks per bit, samples each bit at mid-bit, checks parity and stop bit.
- Presents the received byte with a one-cycle valid or error pulse.
- Sits between the pad and the UART top, beside the transmitter.

Parameters:
INPUT_DATA_WIDTH, 8, data bits per frame
PARITY_ENABLED, 1, 1 = parity bit present after data, 0 = none
PARITY_TYPE, 0, 0 = even, 1 = odd
CLOCKS_PER_BIT, 8, clk cycles per serial bit; even, >= 4
NUMBER_OF_RX_SYNCHRONIZERS, 3, flip-flop stages on serial_in

Ports:
clk  input  1  sole clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
serial_in  input  1  asynchronous serial line, idles high
received_data  output  INPUT_DATA_WIDTH  last received data word, held until next frame completes
data_is_valid  output  1  one-cycle pulse: frame good, received_data updated
rx_error  output  1  one-cycle pulse: parity or stop-bit (framing) error
rx_busy  output  1  high from start-bit detection until stop-bit sample

Behaviour:
- Reset (reset == 0 at a clk edge), values on the following cycle:
  - received_data = 0, data_is_valid = 0, rx_error = 0, rx_busy = 0.
  - State = RX_IDLE; the synchronizer chain is filled with 1s.
  - Reset mid-frame abandons the frame with no pulse.
- Synchronizer: rx_s is the last stage of the chain. It lags serial_in by NUMBER_OF_RX_SYNCHRONIZERS cycles. All decisions use rx_s only.
- Frame: start (0), data LSB first, parity (if enabled), stop (1). NUMBER_OF_BITS = INPUT_DATA_WIDTH + PARITY_ENABLED + 2.
- Counter: tick_cnt, width $clog2(CLOCKS_PER_BIT). bit_idx counts received data bits.
- RX_IDLE:
  - When rx_s == 0, go to RX_START, set rx_busy = 1, load tick_cnt for a half-bit wait.
  - Call this cycle t0.
- RX_START:
  - At t0 + CLOCKS_PER_BIT/2, sample rx_s.
  - If 1: false start; return to RX_IDLE, rx_busy = 0, no pulse.
  - If 0: go to RX_DATA, bit_idx = 0.
- Sampling: every later sample is CLOCKS_PER_BIT cycles after the previous one.
- RX_DATA: shift the sample into data bit bit_idx. After bit INPUT_DATA_WIDTH-1, go to RX_PARITY if PARITY_ENABLED, else RX_STOP.
- RX_PARITY:
  - Sample, then compute expected = (^data) ^ PARITY_TYPE.
  - Latch a mismatch flag; go to RX_STOP.
- RX_STOP: sample the stop bit, go to RX_IDLE and drop rx_busy the same cycle. On the next cycle:
  - Stop == 1 and no parity mismatch: data_is_valid = 1 and received_data updated.
  - Otherwise: rx_error = 1 and received_data unchanged.
- data_is_valid and rx_error are mutually exclusive and last exactly one cycle.
- Latency, defaults (CPB = 8, 11 bits):
  - Stop sample at t0 + 4 + 10*8 = t0 + 84; pulse at t0 + 85.
  - From the serial_in falling edge: 88 cycles.
- Back-to-back frames: RX_IDLE is re-entered at the mid-stop sample, so a start edge one half-bit later is detected with no dead time.
- Line held low (break): stop sample = 0, giving rx_error. The receiver then stays in RX_IDLE until rx_s returns high and falls again; a new frame starts only after rx_s goes 1 then 0.

Decomposition:
- Shared package uart_pkg: RX state encodings RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP; a NUMBER_OF_BITS function/localparam; the parity function.
- The transmitter reuses the same package.
- One sub-module: uart_rx_synchronizer, parameterised depth, reset value 1.

Test Plan:
- Even parity, send 0xA5 (parity 0, stop 1) -> data_is_valid pulse 88 cycles after the start edge, received_data = 0xA5, rx_error = 0.
- Send 0x00, then 0xFF (parity 0) with no idle gap -> two valid pulses 88 cycles apart from the first start edge at the 11-bit pitch; data 0x00 then 0xFF.
- Send 0x01 with parity bit 0 (wrong) -> rx_error pulse at the same time slot, received_data keeps its previous value, no data_is_valid.
- Send 0x3C with stop bit 0 -> rx_error pulse; then a line high for >= 1 bit, then a good frame 0x5A -> valid with 0x5A.
- Low glitch of 2 cycles on serial_in -> rx_busy high for 4 cycles, then back to idle, no pulses.
- reset low at bit 5 of a frame -> all outputs 0 the next cycle; a following full frame 0x96 is received correctly.
